// File: rtl/shift_reg_univ_pkg.sv
// shift_reg_univ_pkg
//   Shared definitions for the universal shift register: the 3-bit operation
//   mode encoding seen on the top-level `mode` port and the per-bit select
//   used inside each sr_cell.
package shift_reg_univ_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_HOLD = 3'd0;
  localparam mode_t MODE_LOAD = 3'd1;
  localparam mode_t MODE_SHL  = 3'd2;
  localparam mode_t MODE_SHR  = 3'd3;
  localparam mode_t MODE_ROL  = 3'd4;
  localparam mode_t MODE_ROR  = 3'd5;

  // Per-bit source select. "Lower" is the bit below (index i-1), which feeds
  // bit i on a left shift; "upper" is index i+1, which feeds it on a right shift.
  typedef enum logic [1:0] {
    CELL_HOLD       = 2'd0,
    CELL_LOAD       = 2'd1,
    CELL_FROM_LOWER = 2'd2,
    CELL_FROM_UPPER = 2'd3
  } cell_sel_e;

endpackage

// File: rtl/shift_reg_univ_cell.sv
// sr_cell
//   One bit of the universal shift register: a flop with a 4-way source mux
//   (hold / parallel load / lower neighbour / upper neighbour) and a
//   synchronous active-low reset to its own RESET_BIT.
// Ports:
//   clk        rising-edge clock
//   resetn     synchronous active-low reset
//   sel        source select for the next value
//   load_bit   parallel load data bit
//   lower_bit  value taken on a left shift (bit i-1 or serial/rotate feed)
//   upper_bit  value taken on a right shift (bit i+1 or serial/rotate feed)
//   q          stored bit
module sr_cell
  import shift_reg_univ_pkg::*;
#(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic      clk,
  input  logic      resetn,
  input  cell_sel_e sel,
  input  logic      load_bit,
  input  logic      lower_bit,
  input  logic      upper_bit,
  output logic      q
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      q <= RESET_BIT;
    end else begin
      case (sel)
        CELL_HOLD:       q <= q;
        CELL_LOAD:       q <= load_bit;
        CELL_FROM_LOWER: q <= lower_bit;
        CELL_FROM_UPPER: q <= upper_bit;
        default:         q <= q;
      endcase
    end
  end

endmodule

// File: rtl/shift_reg_univ.sv
// shift_reg_univ
//   Parametrised universal shift register built from WIDTH sr_cell instances,
//   plus a saturating shift counter with a one-cycle done pulse so it can act
//   as a serialiser/deserialiser front end.
//   Optional feature macro: SHIFT_REG_ROTATE_EN -- when defined, modes 4/5
//   rotate left/right and count as shifts; otherwise they act as HOLD and the
//   rotate feed paths are not built.
// Ports:
//   clk       rising-edge clock
//   resetn    synchronous active-low reset (q=RESET_VALUE, cnt=0, done=0)
//   mode      0 HOLD, 1 LOAD, 2 SHL, 3 SHR, 4 ROL, 5 ROR, 6/7 HOLD
//   din       parallel load data
//   sin_lsb   serial bit entering q[0] on SHL
//   sin_msb   serial bit entering q[WIDTH-1] on SHR
//   q         register contents
//   sout_msb  q[WIDTH-1]
//   sout_lsb  q[0]
//   cnt       shifts since last load/reset, saturating at WIDTH
//   done      one-cycle pulse on the edge where cnt reaches WIDTH
module shift_reg_univ
  import shift_reg_univ_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int              CW          = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic             sin_lsb,
  input  logic             sin_msb,
  output logic [WIDTH-1:0] q,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic [CW-1:0]    cnt,
  output logic             done
);

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  cell_sel_e sel;
  logic      is_shift;
  logic      lsb_feed;
  logic      msb_feed;

`ifdef SHIFT_REG_ROTATE_EN
  logic rotate;

  always_comb begin
    sel      = CELL_HOLD;
    is_shift = 1'b0;
    rotate   = 1'b0;
    case (mode)
      MODE_LOAD: sel = CELL_LOAD;
      MODE_SHL: begin
        sel      = CELL_FROM_LOWER;
        is_shift = 1'b1;
      end
      MODE_SHR: begin
        sel      = CELL_FROM_UPPER;
        is_shift = 1'b1;
      end
      MODE_ROL: begin
        sel      = CELL_FROM_LOWER;
        is_shift = 1'b1;
        rotate   = 1'b1;
      end
      MODE_ROR: begin
        sel      = CELL_FROM_UPPER;
        is_shift = 1'b1;
        rotate   = 1'b1;
      end
      default: ;
    endcase
  end

  // A rotate is a shift whose end-of-register feed is the opposite end bit.
  // For WIDTH=1 this feeds q[0] back into itself, leaving it unchanged.
  assign lsb_feed = rotate ? q[WIDTH-1] : sin_lsb;
  assign msb_feed = rotate ? q[0]       : sin_msb;
`else
  always_comb begin
    sel      = CELL_HOLD;
    is_shift = 1'b0;
    case (mode)
      MODE_LOAD: sel = CELL_LOAD;
      MODE_SHL: begin
        sel      = CELL_FROM_LOWER;
        is_shift = 1'b1;
      end
      MODE_SHR: begin
        sel      = CELL_FROM_UPPER;
        is_shift = 1'b1;
      end
      default: ;
    endcase
  end

  assign lsb_feed = sin_lsb;
  assign msb_feed = sin_msb;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic lower;
    logic upper;

    if (i == 0) begin : g_lo_end
      assign lower = lsb_feed;
    end else begin : g_lo_mid
      assign lower = q[i-1];
    end

    if (i == WIDTH - 1) begin : g_hi_end
      assign upper = msb_feed;
    end else begin : g_hi_mid
      assign upper = q[i+1];
    end

    sr_cell #(
      .RESET_BIT (RESET_VALUE[i])
    ) u_cell (
      .clk       (clk),
      .resetn    (resetn),
      .sel       (sel),
      .load_bit  (din[i]),
      .lower_bit (lower),
      .upper_bit (upper),
      .q         (q[i])
    );
  end

  assign sout_msb = q[WIDTH-1];
  assign sout_lsb = q[0];

  // done is registered alongside cnt, so it is high exactly for the cycle
  // after the shift that moved cnt from WIDTH-1 to WIDTH.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= is_shift && (cnt == CNT_MAX - CW'(1));
      if (sel == CELL_LOAD) begin
        cnt <= '0;
      end else if (is_shift && (cnt != CNT_MAX)) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_shift_reg_univ.sv
module tb_shift_reg_univ;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit DUT
  logic       resetn;
  logic [2:0] mode;
  logic [7:0] din;
  logic       sin_lsb, sin_msb;
  logic [7:0] q;
  logic       sout_msb, sout_lsb;
  logic [3:0] cnt;
  logic       done;

  // 1-bit DUT
  logic       resetn1;
  logic [2:0] mode1;
  logic [0:0] din1;
  logic       sin_lsb1, sin_msb1;
  logic [0:0] q1;
  logic       sout_msb1, sout_lsb1;
  logic [0:0] cnt1;
  logic       done1;

  int n_cmp = 0;
  int n_err = 0;

`ifdef SHIFT_REG_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  // reference model state for the 8-bit DUT
  logic [7:0] mq;
  int         mcnt;
  logic       mdone;

  shift_reg_univ #(.WIDTH(8), .RESET_VALUE(8'h3C)) dut (
    .clk(clk), .resetn(resetn), .mode(mode), .din(din),
    .sin_lsb(sin_lsb), .sin_msb(sin_msb), .q(q),
    .sout_msb(sout_msb), .sout_lsb(sout_lsb), .cnt(cnt), .done(done)
  );

  shift_reg_univ #(.WIDTH(1), .RESET_VALUE(1'b0)) dut1 (
    .clk(clk), .resetn(resetn1), .mode(mode1), .din(din1),
    .sin_lsb(sin_lsb1), .sin_msb(sin_msb1), .q(q1),
    .sout_msb(sout_msb1), .sout_lsb(sout_lsb1), .cnt(cnt1), .done(done1)
  );

  // Drive one cycle on the 8-bit DUT and advance the model by the same cycle.
  task automatic cyc(input logic rn, input logic [2:0] md, input logic [7:0] d,
                     input logic sl, input logic sm);
    bit shift;
    resetn = rn; mode = md; din = d; sin_lsb = sl; sin_msb = sm;
    shift = 1'b0;
    mdone = 1'b0;
    if (!rn) begin
      mq = 8'h3C;
      mcnt = 0;
    end else begin
      case (md)
        3'd1: begin mq = d; mcnt = 0; end
        3'd2: begin mq = (mq << 1) | {7'd0, sl}; shift = 1'b1; end
        3'd3: begin mq = (mq >> 1) | {sm, 7'd0}; shift = 1'b1; end
        3'd4: if (ROT) begin mq = (mq << 1) | (mq >> 7); shift = 1'b1; end
        3'd5: if (ROT) begin mq = (mq >> 1) | (mq << 7); shift = 1'b1; end
        default: ;
      endcase
      if (shift) begin
        mdone = (mcnt == 7);
        if (mcnt < 8) mcnt = mcnt + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cyc(1'b0, 3'd1, 8'hFF, 1'b1, 1'b1);
    n_cmp++;
    if ({q, cnt, done, sout_msb, sout_lsb} !== {8'h3C, 4'd0, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset: got q=%h cnt=%0d done=%b so=%b%b, want q=3c cnt=0 done=0 so=00",
               q, cnt, done, sout_msb, sout_lsb);
    end
  endtask

  task automatic test_shl_fill();
    cyc(1'b1, 3'd1, 8'hA5, 1'b0, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      cyc(1'b1, 3'd2, 8'h00, 1'b1, 1'b0);
      n_cmp++;
      if ({q, cnt, done, sout_msb, sout_lsb} !== {mq, 4'(mcnt), mdone, mq[7], mq[0]}) begin
        n_err++;
        $display("FAIL shl_fill[%0d]: got q=%h cnt=%0d done=%b so=%b%b, want q=%h cnt=%0d done=%b",
                 i, q, cnt, done, sout_msb, sout_lsb, mq, mcnt, mdone);
      end
    end
    n_cmp++;
    if ({q, cnt} !== {8'hFF, 4'd8}) begin
      n_err++;
      $display("FAIL shl_fill_final: got q=%h cnt=%0d, want q=ff cnt=8", q, cnt);
    end
  endtask

  task automatic test_shr_rotate();
    cyc(1'b1, 3'd1, 8'h81, 1'b0, 1'b0);
    cyc(1'b1, 3'd3, 8'h00, 1'b1, 1'b0);
    n_cmp++;
    if ({q, cnt, done} !== {8'h40, 4'd1, 1'b0}) begin
      n_err++;
      $display("FAIL shr: got q=%h cnt=%0d done=%b, want q=40 cnt=1 done=0", q, cnt, done);
    end
    cyc(1'b1, 3'd1, 8'h81, 1'b0, 1'b0);
    cyc(1'b1, 3'd5, 8'h00, 1'b0, 1'b0);
    n_cmp++;
    if ({q, cnt, done} !== {mq, 4'(mcnt), mdone}) begin
      n_err++;
      $display("FAIL ror: got q=%h cnt=%0d done=%b, want q=%h cnt=%0d done=%b",
               q, cnt, done, mq, mcnt, mdone);
    end
    cyc(1'b1, 3'd1, 8'h81, 1'b0, 1'b0);
    cyc(1'b1, 3'd4, 8'h00, 1'b0, 1'b0);
    n_cmp++;
    if ({q, cnt, done} !== {mq, 4'(mcnt), mdone}) begin
      n_err++;
      $display("FAIL rol: got q=%h cnt=%0d done=%b, want q=%h cnt=%0d done=%b",
               q, cnt, done, mq, mcnt, mdone);
    end
`ifdef SHIFT_REG_ROTATE_EN
    n_cmp++;
    if (q !== 8'h03) begin
      n_err++;
      $display("FAIL rol_const: got q=%h, want q=03", q);
    end
`else
    n_cmp++;
    if ({q, cnt} !== {8'h81, 4'd0}) begin
      n_err++;
      $display("FAIL rol_disabled: got q=%h cnt=%0d, want q=81 cnt=0", q, cnt);
    end
`endif
  endtask

  task automatic test_hold_modes();
    logic [2:0] mlist [5] = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    foreach (mlist[k]) begin
      cyc(1'b1, 3'd1, 8'h81, 1'b0, 1'b0);
      for (int c = 0; c < 3; c++) begin
        cyc(1'b1, mlist[k], 8'h5A, 1'b1, 1'b1);
        n_cmp++;
        if ({q, cnt, done, sout_msb, sout_lsb} !== {mq, 4'(mcnt), mdone, mq[7], mq[0]}) begin
          n_err++;
          $display("FAIL hold_mode%0d[%0d]: got q=%h cnt=%0d done=%b, want q=%h cnt=%0d done=%b",
                   mlist[k], c, q, cnt, done, mq, mcnt, mdone);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    cyc(1'b1, 3'd1, 8'h0F, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 3'd2, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 3'd2, 8'h00, 1'b1, 1'b0);
    n_cmp++;
    if ({q, cnt, done} !== {8'h3C, 4'd0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_mid: got q=%h cnt=%0d done=%b, want q=3c cnt=0 done=0", q, cnt, done);
    end
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 3'd3, 8'h00, i[0], 1'b0);
      if (done === 1'b1) pulses++;
      n_cmp++;
      if ({q, cnt, done} !== {mq, 4'(mcnt), mdone}) begin
        n_err++;
        $display("FAIL reset_mid_shr[%0d]: got q=%h cnt=%0d done=%b, want q=%h cnt=%0d done=%b",
                 i, q, cnt, done, mq, mcnt, mdone);
      end
    end
    n_cmp++;
    if (pulses !== 1) begin
      n_err++;
      $display("FAIL reset_mid_pulses: got %0d done pulses, want 1", pulses);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      logic       rn;
      logic [2:0] md;
      rn = ($urandom_range(0, 40) != 0);
      md = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(2, 5)) : 3'($urandom_range(0, 7));
      cyc(rn, md, 8'($urandom), 1'($urandom), 1'($urandom));
      n_cmp++;
      if ({q, cnt, done, sout_msb, sout_lsb} !== {mq, 4'(mcnt), mdone, mq[7], mq[0]}) begin
        n_err++;
        $display("FAIL random[%0d] mode=%0d rn=%b: got q=%h cnt=%0d done=%b so=%b%b, want q=%h cnt=%0d done=%b",
                 i, md, rn, q, cnt, done, sout_msb, sout_lsb, mq, mcnt, mdone);
      end
    end
  endtask

  task automatic test_width1();
    resetn1 = 1'b0; mode1 = 3'd0; din1 = 1'b1; sin_lsb1 = 1'b0; sin_msb1 = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({q1, cnt1, done1} !== 3'b000) begin
      n_err++;
      $display("FAIL w1_reset: got q=%b cnt=%0d done=%b, want 0 0 0", q1, cnt1, done1);
    end
    resetn1 = 1'b1; mode1 = 3'd2; sin_lsb1 = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({q1, cnt1, done1, sout_msb1, sout_lsb1} !== 5'b11111) begin
      n_err++;
      $display("FAIL w1_shl1: got q=%b cnt=%0d done=%b, want 1 1 1", q1, cnt1, done1);
    end
    sin_lsb1 = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({q1, cnt1, done1} !== 3'b010) begin
      n_err++;
      $display("FAIL w1_shl2: got q=%b cnt=%0d done=%b, want 0 1 0", q1, cnt1, done1);
    end
    mode1 = 3'd1; din1 = 1'b0;
    @(posedge clk); #1;
    mode1 = 3'd3; sin_msb1 = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({q1, cnt1, done1} !== 3'b111) begin
      n_err++;
      $display("FAIL w1_shr: got q=%b cnt=%0d done=%b, want 1 1 1", q1, cnt1, done1);
    end
    mode1 = 3'd4;
    @(posedge clk); #1;
    n_cmp++;
    if ({q1, cnt1, done1} !== 3'b110) begin
      n_err++;
      $display("FAIL w1_rol: got q=%b cnt=%0d done=%b, want 1 1 0", q1, cnt1, done1);
    end
    mode1 = 3'd0;
  endtask

  initial begin
    resetn = 1'b0; mode = 3'd0; din = 8'h00; sin_lsb = 1'b0; sin_msb = 1'b0;
    resetn1 = 1'b0; mode1 = 3'd0; din1 = 1'b0; sin_lsb1 = 1'b0; sin_msb1 = 1'b0;
    mq = 8'h3C; mcnt = 0; mdone = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_shl_fill();
    test_shr_rotate();
    test_hold_modes();
    test_reset_mid();
    test_random();
    test_width1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shift_reg_univ.md
# shift_reg_univ

Parametrised universal shift register: WIDTH-bit register with hold, parallel load, logical shift left/right with serial inputs, and optional rotate. A saturating shift counter with a one-cycle `done` pulse lets it act directly as a serialiser/deserialiser front end. It is the generalised successor to the single-bit loadable reset flop cell and is built from a per-bit cell of the same style.

## Interface
- WIDTH, 8: register width in bits; legal range ≥ 1.
- RESET_VALUE, 0: WIDTH-bit value loaded into `q` on reset.
- CW, $clog2(WIDTH+1): width of `cnt`; derived, not overridden.

- clk  in  1  rising-edge clock.
- resetn  in  1  reset; one clock, synchronous, active-low.
- mode  in  3  operation select: 0 HOLD, 1 LOAD, 2 SHL, 3 SHR, 4 ROL, 5 ROR, 6/7 reserved.
- din  in  WIDTH  parallel load data.
- sin_lsb  in  1  serial bit entering q[0] on SHL.
- sin_msb  in  1  serial bit entering q[WIDTH-1] on SHR.
- q  out  WIDTH  register contents.
- sout_msb  out  1  = q[WIDTH-1].
- sout_lsb  out  1  = q[0].
- cnt  out  CW  shifts since last load/reset, saturating at WIDTH.
- done  out  1  one-cycle pulse when `cnt` reaches WIDTH.

## Operation
- Reset (`resetn`=0 at rising edge): q=RESET_VALUE, cnt=0, done=0; reset overrides any mode.
- HOLD: q, cnt unchanged; done=0.
- LOAD: q=din; cnt=0; done=0.
- SHL: q={q[WIDTH-2:0], sin_lsb}; for WIDTH=1, q=sin_lsb.
- SHR: q={sin_msb, q[WIDTH-1:1]}; for WIDTH=1, q=sin_msb.
- ROL: q={q[WIDTH-2:0], q[WIDTH-1]}; ROR: q={q[0], q[WIDTH-1:1]}; WIDTH=1 leaves q unchanged.
- Shift modes (SHL/SHR, plus ROL/ROR when enabled): cnt=min(cnt+1, WIDTH).
- done=1 for exactly the cycle after the edge where cnt goes WIDTH-1 → WIDTH; further shifts at saturation keep cnt=WIDTH, done=0.
- Reserved modes 6/7: behave as HOLD.
- Direction may change between consecutive shifts; the counter counts all shifts regardless of direction.

## Timing
- q, cnt, done registered; update one edge after mode/data are sampled; latency 1 cycle.
- sout_msb/sout_lsb are combinational from q (no extra latency), valid the cycle q is valid.
- Reset values: q=RESET_VALUE, sout_* = corresponding RESET_VALUE bits, cnt=0, done=0.
- Reset mid-shift sequence: cnt cleared, no done pulse, sequence restarts from RESET_VALUE.
- LOAD on the cycle cnt would reach WIDTH: LOAD wins, no done.
- No handshake; caller drives mode every cycle, HOLD when idle.

## Configuration
- SHIFT_REG_ROTATE_EN defined: modes 4/5 perform ROL/ROR and count as shifts.
- Not defined: modes 4/5 behave as HOLD (q, cnt unchanged, done=0); rotate mux paths absent.

## Structure
- Shared package: mode encoding constants (MODE_HOLD..MODE_ROR) and 3-bit mode type.
- Sub-module `sr_cell`: one bit; mux selecting hold/load/left-neighbour/right-neighbour with synchronous active-low reset to its RESET_VALUE bit; instantiated WIDTH times via generate.
- Counter and done logic in the top level.

## Test plan
- Reset with RESET_VALUE=8'h3C, mode=LOAD, din=8'hFF → q=8'h3C, cnt=0, done=0.
- LOAD 8'hA5 then 8× SHL with sin_lsb=1 → q=8'hFF after 8 shifts, cnt=8, done high only after 8th edge; 9th SHL → cnt=8, done=0.
- LOAD 8'h81, SHR with sin_msb=0 → 8'h40; with macro, LOAD 8'h81, ROR → 8'hC0, ROL → 8'h03.
- Macro undefined: LOAD 8'h81, mode=4 for 3 cycles → q=8'h81, cnt=0, done=0; same for modes 6/7 with macro defined.
- LOAD 8'h0F, 5× SHL, resetn=0 one cycle, then 8× SHR → cnt restarts at 0 after reset, done pulses once after 8th SHR.
- WIDTH=1: SHL with sin_lsb=1 → q=1, cnt=1, done pulses; second SHL → cnt=1, done=0.
